output_arbiter: RTL and testbench

Per-output-port packet arbiter of the 4-port switch. Sits directly upstream of `output_mux`: collects requests from the four input ports that target this output, selects one by round-robin, and holds that grant for a whole packet. Drives `mux_sel` and `arb_active`, which steer the 4:1 data mux and qualify its `valid_out`. One instance per output port.

---
 rtl/switch_pkg.sv | 19 +
 rtl/output_arbiter_if.sv | 28 ++
 rtl/output_arbiter_rr_pick4.sv | 34 +++
 rtl/output_arbiter.sv | 136 +++++++++++++
 tb/tb_output_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared types and constants for the 4-port switch output arbiter.
//   NUM_PORTS    - number of input ports competing for one output
//   PORT_IDX_W   - width of a binary port index
//   arb_state_t  - arbiter FSM states (IDLE, GRANT)
//   port_mask_t  - one bit per input port
package switch_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int PORT_IDX_W = 2;

    typedef logic [NUM_PORTS-1:0]  port_mask_t;
    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/output_arbiter_if.sv
// output_arbiter_if: request/grant bundle between the input ports and one
// output arbiter.
//   req, eop, out_ready              - driven by the requesting side (master)
//   grant, mux_sel, arb_active,
//   xfer, timeout_err                - driven by the arbiter (slave)
interface output_arbiter_if;
    import switch_pkg::*;

    port_mask_t req;
    port_mask_t eop;
    logic       out_ready;
    port_mask_t grant;
    port_idx_t  mux_sel;
    logic       arb_active;
    logic       xfer;
    logic       timeout_err;

    modport master (
        output req, eop, out_ready,
        input  grant, mux_sel, arb_active, xfer, timeout_err
    );

    modport slave (
        input  req, eop, out_ready,
        output grant, mux_sel, arb_active, xfer, timeout_err
    );

endinterface

// File: rtl/output_arbiter_rr_pick4.sv
// rr_pick4: combinational rotating-priority selector over four requests.
//   req    - request mask
//   ptr    - highest-priority index; search order ptr, ptr+1, ... mod 4
//   found  - at least one request is set
//   idx    - binary index of the winner (0 when nothing found)
//   onehot - one-hot winner (0 when nothing found)
module rr_pick4
    import switch_pkg::*;
(
    input  port_mask_t req,
    input  port_idx_t  ptr,
    output logic       found,
    output port_idx_t  idx,
    output port_mask_t onehot
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Index wraps naturally in the 2-bit port_idx_t.
            automatic port_idx_t cand = ptr + port_idx_t'(i);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: per-output-port packet arbiter. Round-robin selects one of
// four requesting input ports and holds the grant until that port's eop word
// is transferred, then re-arbitrates in the same cycle (no idle bubble).
//   MAX_PKT_CYCLES - grant-hold limit, used only with ARB_TIMEOUT_EN
//   clk            - rising-edge clock
//   rst            - synchronous active-high reset
//   bus (slave)    - req/eop/out_ready in; grant/mux_sel/arb_active/xfer/
//                    timeout_err out
// Optional feature: define ARB_TIMEOUT_EN to compile in the grant watchdog,
// which forces a release and pulses timeout_err after MAX_PKT_CYCLES cycles.
module output_arbiter
    import switch_pkg::*;
#(
    parameter int MAX_PKT_CYCLES = 64
) (
    input logic               clk,
    input logic               rst,
    output_arbiter_if.slave   bus
);

    arb_state_t state_q, state_d;
    port_mask_t grant_q, grant_d;
    port_idx_t  mux_sel_q, mux_sel_d;
    port_idx_t  rr_ptr_q, rr_ptr_d;

    logic       pick_found;
    port_idx_t  pick_idx;
    port_mask_t pick_onehot;
    port_idx_t  pick_ptr;
    port_idx_t  next_after_owner;

    logic       arb_active;
    logic       xfer;
    logic       normal_release;
    logic       timeout_hit;
    logic       release_now;
    logic       load;

    assign next_after_owner = mux_sel_q + port_idx_t'(1);

    // In GRANT the picker only matters on release, where priority must already
    // reflect the advanced pointer so the old owner ranks last.
    assign pick_ptr = (state_q == GRANT) ? next_after_owner : rr_ptr_q;

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign arb_active     = (state_q == GRANT) && bus.req[mux_sel_q];
    assign xfer           = arb_active && bus.out_ready;
    assign normal_release = xfer && bus.eop[mux_sel_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_PKT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // A normal release in the limit cycle wins and suppresses the error.
    assign timeout_hit = (state_q == GRANT) && !normal_release
                      && (cnt_q == CNT_W'(MAX_PKT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (state_q == GRANT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic cfg_unused;
    assign cfg_unused  = |MAX_PKT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign release_now = normal_release || timeout_hit;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mux_sel_d = mux_sel_q;
        rr_ptr_d  = rr_ptr_q;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    load    = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_d = next_after_owner;
                    if (pick_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            grant_d   = pick_onehot;
            mux_sel_d = pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            mux_sel_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            mux_sel_q <= mux_sel_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.mux_sel     = mux_sel_q;
    assign bus.arb_active  = arb_active;
    assign bus.xfer        = xfer;
    assign bus.timeout_err = timeout_hit;

endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed self-checking bench for output_arbiter.
// Instantiated with MAX_PKT_CYCLES=8; watchdog expectations follow
// ARB_TIMEOUT_EN when the bench is compiled with it.
module tb_output_arbiter;
    import switch_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    output_arbiter_if bus ();

    output_arbiter #(.MAX_PKT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input port_mask_t r, input port_mask_t e, input logic rdy);
        bus.req       = r;
        bus.eop       = e;
        bus.out_ready = rdy;
        #1;
    endtask

    initial begin
        port_mask_t exp_g;
        logic       rdy;
        logic       to_exp;
        n_checks = 0;
        n_pass   = 0;

        // Reset state
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0);
        cyc();
        cyc();
        check("rst_grant", bus.grant, 0);
        check("rst_mux_sel", bus.mux_sel, 0);
        check("rst_arb_active", bus.arb_active, 0);
        check("rst_xfer", bus.xfer, 0);
        check("rst_timeout", bus.timeout_err, 0);

        // 1: single request on port 2, one-cycle latency
        rst = 1'b0;
        drive(4'b0100, 4'b0000, 1'b1);
        check("t1_idle_grant", bus.grant, 0);
        cyc();
        check("t1_grant", bus.grant, 4'b0100);
        check("t1_mux_sel", bus.mux_sel, 2);
        check("t1_arb_active", bus.arb_active, 1);
        check("t1_xfer", bus.xfer, 1);

        // 6: reset mid-packet, then fresh all-request grants port 0
        rst = 1'b1;
        cyc();
        check("t6_grant", bus.grant, 0);
        check("t6_mux_sel", bus.mux_sel, 0);
        check("t6_arb_active", bus.arb_active, 0);
        check("t6_xfer", bus.xfer, 0);
        check("t6_timeout", bus.timeout_err, 0);
        rst = 1'b0;
        drive(4'b1111, 4'b0000, 1'b1);
        check("t6_idle_grant", bus.grant, 0);
        cyc();
        check("t6_fresh_grant", bus.grant, 4'b0001);
        check("t6_fresh_mux", bus.mux_sel, 0);

        // 2: all requesting, 1-word packets: 0,1,2,3,0 with no idle cycle
        drive(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            check($sformatf("t2_grant_%0d", i), bus.grant, exp_g);
            check($sformatf("t2_xfer_%0d", i), bus.xfer, 1);
            cyc();
        end
        check("t2_after_grant", bus.grant, 4'b0010);

        // 3: port 1 4-word packet with out_ready toggling; eop without xfer
        // at k=1 must be ignored, req[3] must not preempt
        for (int k = 0; k < 7; k++) begin
            rdy = (k % 2 == 0);
            drive(4'b1010, (k == 1 || k == 6) ? 4'b0010 : 4'b0000, rdy);
            check($sformatf("t3_grant_%0d", k), bus.grant, 4'b0010);
            check($sformatf("t3_xfer_%0d", k), bus.xfer, {31'd0, rdy});
            cyc();
        end
        check("t3_next_grant", bus.grant, 4'b1000);
        check("t3_next_mux", bus.mux_sel, 3);

        // 4: granted req drops for two cycles mid-packet
        drive(4'b1000, 4'b0000, 1'b1);
        check("t4_active", bus.arb_active, 1);
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(4'b0001, 4'b0000, 1'b1);
            check($sformatf("t4_drop_active_%0d", k), bus.arb_active, 0);
            check($sformatf("t4_drop_xfer_%0d", k), bus.xfer, 0);
            check($sformatf("t4_drop_grant_%0d", k), bus.grant, 4'b1000);
            cyc();
        end
        drive(4'b1000, 4'b0000, 1'b1);
        check("t4_back_active", bus.arb_active, 1);
        cyc();
        drive(4'b1001, 4'b1000, 1'b1);
        check("t4_eop_xfer", bus.xfer, 1);
        cyc();
        check("t4_next_grant", bus.grant, 4'b0001);
        check("t4_next_mux", bus.mux_sel, 0);

        // 5: port 2 never ends its packet while port 3 waits
        drive(4'b0101, 4'b0001, 1'b1);
        cyc();
        check("t5_grant2", bus.grant, 4'b0100);
        drive(4'b1100, 4'b0000, 1'b1);
        for (int c = 1; c <= 8; c++) begin
`ifdef ARB_TIMEOUT_EN
            to_exp = (c == 8);
`else
            to_exp = 1'b0;
`endif
            check($sformatf("t5_timeout_%0d", c), bus.timeout_err, {31'd0, to_exp});
            check($sformatf("t5_hold_%0d", c), bus.grant, 4'b0100);
            cyc();
        end
`ifdef ARB_TIMEOUT_EN
        check("t5_moved_grant", bus.grant, 4'b1000);
        check("t5_moved_mux", bus.mux_sel, 3);
`else
        for (int c = 0; c < 64; c++) begin
            if (bus.timeout_err !== 1'b0 || bus.grant !== 4'b0100) begin
                check("t5_long_hold_timeout", bus.timeout_err, 0);
                check("t5_long_hold_grant", bus.grant, 4'b0100);
            end
            cyc();
        end
        check("t5_final_grant", bus.grant, 4'b0100);
        check("t5_final_timeout", bus.timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
